// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: control state encoding.
package shift_add_multiplier_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/shift_add_multiplier_ripple_adder.sv
// Ripple-carry adder built from single-bit full-adder cells.

module full_adder (
   input  logic x_i,
   input  logic y_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);
   assign sum_o  = x_i ^ y_i ^ cin_i;
   assign cout_o = (x_i & y_i) | (cin_i & (x_i ^ y_i));
endmodule

module ripple_adder #(
   parameter int WIDTH = 8
) (
   output logic             cout_o,
   output logic [WIDTH-1:0] sum_o,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             cin_i
);
   logic [WIDTH:0] carry;

   assign carry[0] = cin_i;

   // One full-adder cell per bit; carry ripples from LSB to MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .x_i    (x_i[i]),
         .y_i    (y_i[i]),
         .cin_i  (carry[i]),
         .sum_o  (sum_o[i]),
         .cout_o (carry[i+1])
      );
   end

   assign cout_o = carry[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential multiplier: one partial-product add per cycle, fixed
// WIDTH-cycle latency, valid/ready handshake on operands and product.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               busy_o
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        count_q, count_d;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 cout;

   // Multiplicand is added only when the current multiplier bit (ACC LSB) is set.
   assign addend = acc_q[0] ? mcand_q : '0;

   ripple_adder #(.WIDTH(WIDTH)) u_adder (
      .cout_o (cout),
      .sum_o  (sum),
      .x_i    (acc_q[2*WIDTH-1:WIDTH]),
      .y_i    (addend),
      .cin_i  (1'b0)
   );

   // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               mcand_d = a_i;
               acc_d   = {{WIDTH{1'b0}}, b_i};
               count_d = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Carry-out lands in the ACC MSB so the top bit of the product is kept.
            acc_d   = {cout, sum, acc_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything and aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking so all registers update from the same pre-edge values.
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   // Handshake flags depend on state only, so no combinational path from the inputs.
   assign in_ready_o  = (state_q == S_IDLE);
   assign busy_o      = (state_q == S_CALC);
   assign out_valid_o = (state_q == S_DONE);
   assign product_o   = acc_q;

endmodule
